// File: rtl/fc_pkg.sv
// Shared constants and FSM state encoding for the FC feature-map writer.
package fc_pkg;
    localparam int BYTE_W           = 8;
    localparam int LANES            = 8;
    localparam int FM_WORDS_DEFAULT = 48;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        START,
        DONE
    } fc_state_e;
endpackage

// File: rtl/fc_byte_packer.sv
// Packs accepted bytes little-endian into a word; word_vld/word_dat are combinational in the completing cycle.
// No backpressure of its own: every in_vld byte is absorbed; lanes above a last byte read as zero.
module fc_byte_packer
    import fc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_vld,
    input  logic [BYTE_W-1:0]         in_dat,
    input  logic                      in_last,
    output logic                      word_vld,
    output logic [LANES*BYTE_W-1:0]   word_dat
);
    localparam int LANE_W = $clog2(LANES);

    logic [LANE_W-1:0]        lane_q;
    logic [LANES*BYTE_W-1:0]  pack_q;
    logic [LANES*BYTE_W-1:0]  merged;

    always_comb begin
        merged = pack_q;
        merged[lane_q*BYTE_W +: BYTE_W] = in_dat;
    end

    assign word_vld = in_vld && ((lane_q == LANE_W'(LANES - 1)) || in_last);
    assign word_dat = merged;

    // Clearing after each word guarantees unfilled lanes of a short word are zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            lane_q <= '0;
            pack_q <= '0;
        end else if (in_vld) begin
            if (word_vld) begin
                lane_q <= '0;
                pack_q <= '0;
            end else begin
                lane_q <= lane_q + 1'b1;
                pack_q <= merged;
            end
        end
    end
endmodule

// File: rtl/fc_fm_writer.sv
// Streams bytes into FM SRAM words at base+n, zero-pads to FM_WORDS, then pulses o_fc_start; write 1 cycle after word completes.
// o_act_ready is high only while filling and drops the cycle after the terminating byte (last or overflow).
module fc_fm_writer #(
    parameter int FM_WORDS = 48,
    parameter int LANES    = 8,
    parameter int ADDR_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8:0]            i_base_addr,
    input  logic                  i_frame_start,
    input  logic                  i_act_valid,
    input  logic [7:0]            i_act_data,
    input  logic                  i_act_last,
    output logic                  o_act_ready,
    output logic                  o_fm_wr_en,
    output logic [ADDR_W-1:0]     o_fm_wr_addr,
    output logic [LANES*8-1:0]    o_fm_wr_data,
    output logic                  o_fc_start,
    output logic                  o_busy,
    output logic                  o_err
);
    import fc_pkg::*;

    localparam int                CNT_W     = $clog2(FM_WORDS + 1);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FM_WORDS - 1);

    fc_state_e               state_q, state_d;
    logic [8:0]              base_q;
    logic [CNT_W-1:0]        word_cnt_q;
    logic                    accept;
    logic                    start_frame;
    logic                    wr_go;
    logic                    wr_zero;
    logic                    set_err;
    logic                    ready_d;
    logic                    busy_d;
    logic                    fc_start_d;
    logic                    word_vld;
    logic [LANES*8-1:0]      word_dat;

    assign accept = o_act_ready & i_act_valid;

    fc_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_frame),
        .in_vld   (accept),
        .in_dat   (i_act_data),
        .in_last  (i_act_last),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        wr_go       = 1'b0;
        wr_zero     = 1'b0;
        set_err     = 1'b0;
        ready_d     = o_act_ready;
        busy_d      = o_busy;
        fc_start_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (i_frame_start) begin
                    start_frame = 1'b1;
                    ready_d     = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (word_vld) begin
                    wr_go = 1'b1;
                    if (i_act_last) begin
                        ready_d = 1'b0;
                        state_d = (word_cnt_q < LAST_WORD) ? PAD : START;
                    end else if (word_cnt_q == LAST_WORD) begin
                        ready_d = 1'b0;
                        set_err = 1'b1;
                        state_d = START;
                    end
                end
            end
            PAD: begin
                wr_go   = 1'b1;
                wr_zero = 1'b1;
                if (word_cnt_q == LAST_WORD) state_d = START;
            end
            START: begin
                // START spans the final write cycle, so the registered pulse lands one cycle later.
                fc_start_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q       <= '0;
            word_cnt_q   <= '0;
            o_act_ready  <= 1'b0;
            o_fm_wr_en   <= 1'b0;
            o_fm_wr_addr <= '0;
            o_fm_wr_data <= '0;
            o_fc_start   <= 1'b0;
            o_busy       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_act_ready <= ready_d;
            o_busy      <= busy_d;
            o_fc_start  <= fc_start_d;
            o_fm_wr_en  <= wr_go;
            if (start_frame) begin
                base_q     <= i_base_addr;
                word_cnt_q <= '0;
                o_err      <= 1'b0;
            end
            if (set_err) o_err <= 1'b1;
            if (wr_go) begin
                o_fm_wr_addr <= ADDR_W'(base_q) + ADDR_W'(word_cnt_q);
                o_fm_wr_data <= wr_zero ? '0 : word_dat;
                word_cnt_q   <= word_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fc_fm_writer.sv
// Scoreboard bench for fc_fm_writer: expected writes are queued when a frame is driven and popped on each SRAM write.
module tb_fc_fm_writer;
    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  i_base_addr = '0;
    logic        i_frame_start = 1'b0;
    logic        i_act_valid = 1'b0;
    logic [7:0]  i_act_data = '0;
    logic        i_act_last = 1'b0;
    logic        o_act_ready;
    logic        o_fm_wr_en;
    logic [15:0] o_fm_wr_addr;
    logic [63:0] o_fm_wr_data;
    logic        o_fc_start;
    logic        o_busy;
    logic        o_err;

    wr_t         exp_q[$];
    logic [7:0]  stim[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          fc_cnt = 0;
    int          last_wr_cyc = -10;
    bit          mark_first = 1'b0;
    logic [15:0] first_addr = '0;
    logic [63:0] first_data = '0;

    fc_fm_writer #(.FM_WORDS(48), .LANES(8), .ADDR_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_base_addr   (i_base_addr),
        .i_frame_start (i_frame_start),
        .i_act_valid   (i_act_valid),
        .i_act_data    (i_act_data),
        .i_act_last    (i_act_last),
        .o_act_ready   (o_act_ready),
        .o_fm_wr_en    (o_fm_wr_en),
        .o_fm_wr_addr  (o_fm_wr_addr),
        .o_fm_wr_data  (o_fm_wr_data),
        .o_fc_start    (o_fc_start),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        wr_t e;
        if (o_fm_wr_en) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (mark_first) begin
                first_addr = o_fm_wr_addr;
                first_data = o_fm_wr_data;
                mark_first = 1'b0;
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr %h data %h, required no write", o_fm_wr_addr, o_fm_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (o_fm_wr_addr !== e.addr || o_fm_wr_data !== e.data) begin
                    n_fail++;
                    $display("FAIL write_scoreboard: got addr %h data %h, required addr %h data %h",
                             o_fm_wr_addr, o_fm_wr_data, e.addr, e.data);
                end
            end
        end
        if (o_fc_start) begin
            fc_cnt++;
            n_checks++;
            if (cyc != last_wr_cyc + 1 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL fc_start_timing: got gap %0d busy %b, required gap 1 busy 0", cyc - last_wr_cyc, o_busy);
            end
        end
    end

    // Queues the 48 expected writes for stim[] at base, then streams the bytes.
    task automatic drive_frame(input logic [8:0] base, input bit last_en, input bit gaps,
                               input int fs_at, output int acc);
        int nacc;
        int idx;
        int guard;
        bit phase;
        logic [63:0] w;
        wr_t e;
        nacc = (stim.size() > 384) ? 384 : stim.size();
        for (int wi = 0; wi < 48; wi++) begin
            w = '0;
            for (int l = 0; l < 8; l++)
                if (wi * 8 + l < nacc) w[l*8 +: 8] = stim[wi*8+l];
            e.addr = 16'(base) + 16'(wi);
            e.data = w;
            exp_q.push_back(e);
        end
        @(negedge clk);
        i_base_addr   = base;
        i_frame_start = 1'b1;
        @(negedge clk);
        i_frame_start = 1'b0;
        idx = 0;
        guard = 0;
        phase = 1'b0;
        while (idx < stim.size() && guard < 3000) begin
            guard++;
            if (!o_act_ready && idx > 0) break;
            phase = !phase;
            i_frame_start = (fs_at >= 0 && idx == fs_at);
            if (i_frame_start) i_base_addr = 9'h055;
            if (gaps && !phase) begin
                i_act_valid = 1'b0;
                i_act_last  = 1'b0;
            end else begin
                i_act_valid = 1'b1;
                i_act_data  = stim[idx];
                i_act_last  = last_en && (idx == stim.size() - 1);
            end
            if (o_act_ready && i_act_valid) idx++;
            @(negedge clk);
        end
        i_act_valid   = 1'b0;
        i_act_last    = 1'b0;
        i_frame_start = 1'b0;
        acc = idx;
    endtask

    task automatic wait_done(input int fc0);
        for (int i = 0; i < 400 && fc_cnt == fc0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_act_ready, o_fm_wr_en, o_fm_wr_addr, o_fm_wr_data, o_fc_start, o_busy, o_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy %b en %b addr %h data %h st %b busy %b err %b, required all 0",
                     o_act_ready, o_fm_wr_en, o_fm_wr_addr, o_fm_wr_data, o_fc_start, o_busy, o_err);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_act_ready !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got rdy %b busy %b, required 0 0", o_act_ready, o_busy);
        end
    endtask

    task automatic test_short_frame();
        int fc0, w0, acc;
        stim.delete();
        for (int i = 0; i < 128; i++) stim.push_back(8'(i + 1));
        fc0 = fc_cnt; w0 = wr_cnt; mark_first = 1'b1;
        drive_frame(9'h010, 1'b1, 1'b0, -1, acc);
        wait_done(fc0);
        n_checks++;
        if (first_addr !== 16'h0010 || first_data !== 64'h0807060504030201) begin
            n_fail++;
            $display("FAIL short_first_word: got %h/%h, required 0010/0807060504030201", first_addr, first_data);
        end
        n_checks++;
        if (fc_cnt - fc0 != 1 || wr_cnt - w0 != 48 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL short_frame: got starts %0d writes %0d left %0d, required 1 48 0", fc_cnt - fc0, wr_cnt - w0, exp_q.size());
        end
        n_checks++;
        if (o_err !== 1'b0 || o_busy !== 1'b0 || o_act_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL short_done_flags: got err %b busy %b rdy %b, required 0 0 0", o_err, o_busy, o_act_ready);
        end
    endtask

    task automatic test_full_frame();
        int fc0, w0, acc;
        stim.delete();
        for (int i = 0; i < 384; i++) stim.push_back(8'(i * 37 + 11));
        fc0 = fc_cnt; w0 = wr_cnt;
        drive_frame(9'h100, 1'b1, 1'b0, -1, acc);
        wait_done(fc0);
        n_checks++;
        if (fc_cnt - fc0 != 1 || wr_cnt - w0 != 48 || exp_q.size() != 0 || acc != 384) begin
            n_fail++;
            $display("FAIL full_frame: got starts %0d writes %0d left %0d acc %0d, required 1 48 0 384",
                     fc_cnt - fc0, wr_cnt - w0, exp_q.size(), acc);
        end
        n_checks++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_frame_err: got %b, required 0", o_err);
        end
    endtask

    task automatic test_sign_bytes();
        int fc0, w0, acc;
        stim.delete();
        stim.push_back(8'hFF); stim.push_back(8'h80); stim.push_back(8'h7F);
        fc0 = fc_cnt; w0 = wr_cnt; mark_first = 1'b1;
        drive_frame(9'h1F8, 1'b1, 1'b0, -1, acc);
        wait_done(fc0);
        n_checks++;
        if (first_addr !== 16'h01F8 || first_data !== 64'h00000000007F80FF) begin
            n_fail++;
            $display("FAIL sign_first_word: got %h/%h, required 01f8/00000000007f80ff", first_addr, first_data);
        end
        n_checks++;
        if (fc_cnt - fc0 != 1 || wr_cnt - w0 != 48 || exp_q.size() != 0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sign_frame: got starts %0d writes %0d left %0d err %b, required 1 48 0 0",
                     fc_cnt - fc0, wr_cnt - w0, exp_q.size(), o_err);
        end
    endtask

    task automatic test_overflow();
        int fc0, w0, acc;
        stim.delete();
        for (int i = 0; i < 400; i++) stim.push_back(8'(i) ^ 8'h5A);
        fc0 = fc_cnt; w0 = wr_cnt;
        drive_frame(9'h002, 1'b0, 1'b0, -1, acc);
        wait_done(fc0);
        n_checks++;
        if (acc != 384) begin
            n_fail++;
            $display("FAIL overflow_accepted: got %0d bytes, required 384", acc);
        end
        n_checks++;
        if (o_err !== 1'b1 || fc_cnt - fc0 != 1 || wr_cnt - w0 != 48 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL overflow_frame: got err %b starts %0d writes %0d left %0d, required 1 1 48 0",
                     o_err, fc_cnt - fc0, wr_cnt - w0, exp_q.size());
        end
    endtask

    task automatic test_valid_gaps();
        int fc0, w0, acc;
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(8'($urandom_range(0, 255)));
        fc0 = fc_cnt; w0 = wr_cnt;
        drive_frame(9'h040, 1'b1, 1'b1, 20, acc);
        wait_done(fc0);
        n_checks++;
        if (fc_cnt - fc0 != 1 || wr_cnt - w0 != 48 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL gaps_frame: got starts %0d writes %0d left %0d, required 1 48 0", fc_cnt - fc0, wr_cnt - w0, exp_q.size());
        end
        n_checks++;
        if (o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_err_cleared: got %b, required 0", o_err);
        end
    endtask

    task automatic test_reset_in_pad();
        int fc0, w0, acc;
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(8'(8'hC0 + i));
        fc0 = fc_cnt; w0 = wr_cnt;
        drive_frame(9'h080, 1'b1, 1'b0, -1, acc);
        for (int i = 0; i < 100 && wr_cnt - w0 < 6; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_act_ready, o_fm_wr_en, o_fm_wr_addr, o_fm_wr_data, o_fc_start, o_busy, o_err} !== '0) begin
            n_fail++;
            $display("FAIL pad_reset_outputs: got rdy %b en %b addr %h data %h st %b busy %b, required all 0",
                     o_act_ready, o_fm_wr_en, o_fm_wr_addr, o_fm_wr_data, o_fc_start, o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        n_checks++;
        if (fc_cnt != fc0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pad_reset_no_start: got starts %0d busy %b, required 0 0", fc_cnt - fc0, o_busy);
        end
        exp_q.delete();
        stim.delete();
        for (int i = 0; i < 24; i++) stim.push_back(8'(i * 3));
        fc0 = fc_cnt; w0 = wr_cnt;
        drive_frame(9'h000, 1'b1, 1'b0, -1, acc);
        wait_done(fc0);
        n_checks++;
        if (fc_cnt - fc0 != 1 || wr_cnt - w0 != 48 || exp_q.size() != 0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_frame: got starts %0d writes %0d left %0d err %b, required 1 48 0 0",
                     fc_cnt - fc0, wr_cnt - w0, exp_q.size(), o_err);
        end
    endtask

    initial begin
        test_reset();
        test_short_frame();
        test_full_frame();
        test_sign_bytes();
        test_overflow();
        test_valid_gaps();
        test_reset_in_pad();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
